// File: rtl/cplx_mult_pkg.sv
// Shared constants and width helpers for the complex multiplier.
package cplx_mult_pkg;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // Full-precision product width for two signed operands.
  function automatic int unsigned prod_width(input int unsigned w_i, input int unsigned w_ii);
    return w_i + w_ii;
  endfunction

  // Sum/difference width: one guard bit over the product, so no overflow is possible.
  function automatic int unsigned sum_width(input int unsigned w_i, input int unsigned w_ii);
    return w_i + w_ii + 1;
  endfunction

endpackage

// File: rtl/sat_wrap_reduce.sv
// Combinational signed width reducer: sign-extend, wrap or saturate.
module sat_wrap_reduce
  import cplx_mult_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 9,
  parameter int unsigned OUT_WIDTH = 4,
  parameter int unsigned MODE      = MODE_SAT
) (
  input  logic [IN_WIDTH-1:0]  din,
  output logic [OUT_WIDTH-1:0] dout_c
);

  generate
    if (OUT_WIDTH >= IN_WIDTH) begin : g_ext
      // Output is wide enough: plain sign extension.
      assign dout_c = OUT_WIDTH'($signed(din));
    end else if (MODE == MODE_WRAP) begin : g_wrap
      // Keep the low bits; the discarded high bits are intentionally dropped.
      logic unused_hi;
      assign unused_hi = ^din[IN_WIDTH-1:OUT_WIDTH];
      assign dout_c    = din[OUT_WIDTH-1:0];
    end else begin : g_sat
      localparam int unsigned HW = IN_WIDTH - OUT_WIDTH + 1;
      logic [HW-1:0] head;
      assign head = din[IN_WIDTH-1:OUT_WIDTH-1];
      // In range when every bit above the output sign bit matches it; else clamp by sign.
      always_comb begin
        dout_c = din[OUT_WIDTH-1:0];
        if ((head != '0) && (head != '1)) begin
          dout_c = din[IN_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                   : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
      end
    end
  endgenerate

endmodule

// File: rtl/cplx_mult.sv
// Two-stage pipelined signed complex multiplier with wrap/saturate output reduction.
module cplx_mult
  import cplx_mult_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH_I  = 4,
  parameter int unsigned INPUT_WIDTH_II = 4,
  parameter int unsigned OUTPUT_WIDTH   = 4,
  parameter int unsigned WRAP_SATURATE  = MODE_SAT
) (
  input  logic                      i_clk,
  input  logic                      i_rst_p,
  input  logic [INPUT_WIDTH_I-1:0]  i_a,
  input  logic [INPUT_WIDTH_I-1:0]  i_b,
  input  logic [INPUT_WIDTH_II-1:0] i_c,
  input  logic [INPUT_WIDTH_II-1:0] i_d,
  input  logic                      i_valid_data,
  output logic [OUTPUT_WIDTH-1:0]   o_r,
  output logic [OUTPUT_WIDTH-1:0]   o_im,
  output logic                      o_valid_data
);

  localparam int unsigned WP = prod_width(INPUT_WIDTH_I, INPUT_WIDTH_II);
  localparam int unsigned WS = sum_width(INPUT_WIDTH_I, INPUT_WIDTH_II);

  logic signed [WP-1:0]     ac_q, bd_q, ad_q, bc_q;
  logic                     v1_q;
  logic signed [WS-1:0]     r_sum_c, im_sum_c;
  logic [OUTPUT_WIDTH-1:0]  r_red_c, im_red_c;

  // Stage 1: full-width signed products, loaded only on valid input.
  always_ff @(posedge i_clk) begin
    if (i_rst_p) begin
      ac_q <= '0;
      bd_q <= '0;
      ad_q <= '0;
      bc_q <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= i_valid_data;
      if (i_valid_data) begin
        ac_q <= WP'($signed(i_a)) * WP'($signed(i_c));
        bd_q <= WP'($signed(i_b)) * WP'($signed(i_d));
        ad_q <= WP'($signed(i_a)) * WP'($signed(i_d));
        bc_q <= WP'($signed(i_b)) * WP'($signed(i_c));
      end
    end
  end

  // Real difference and imaginary sum carried with one guard bit.
  assign r_sum_c  = WS'(ac_q) - WS'(bd_q);
  assign im_sum_c = WS'(ad_q) + WS'(bc_q);

  sat_wrap_reduce #(
    .IN_WIDTH  (WS),
    .OUT_WIDTH (OUTPUT_WIDTH),
    .MODE      (WRAP_SATURATE)
  ) u_reduce_r (
    .din    (r_sum_c),
    .dout_c (r_red_c)
  );

  sat_wrap_reduce #(
    .IN_WIDTH  (WS),
    .OUT_WIDTH (OUTPUT_WIDTH),
    .MODE      (WRAP_SATURATE)
  ) u_reduce_im (
    .din    (im_sum_c),
    .dout_c (im_red_c)
  );

  // Stage 2: register reduced results; outputs hold the last valid result.
  always_ff @(posedge i_clk) begin
    if (i_rst_p) begin
      o_r          <= '0;
      o_im         <= '0;
      o_valid_data <= 1'b0;
    end else begin
      o_valid_data <= v1_q;
      if (v1_q) begin
        o_r  <= r_red_c;
        o_im <= im_red_c;
      end
    end
  end

endmodule

// File: tb/tb_cplx_mult.sv
// Self-checking bench for cplx_mult: saturating and wrapping instances share stimulus.
module tb_cplx_mult;

  localparam int OW = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       vin;
  logic [3:0] a, b, c, d;
  logic [3:0] r_s, im_s, r_w, im_w;
  logic       v_s, v_w;

  always #5 clk = ~clk;

  cplx_mult #(
    .INPUT_WIDTH_I (4), .INPUT_WIDTH_II (4), .OUTPUT_WIDTH (4),
    .WRAP_SATURATE (cplx_mult_pkg::MODE_SAT)
  ) dut_sat (
    .i_clk (clk), .i_rst_p (rst), .i_a (a), .i_b (b), .i_c (c), .i_d (d),
    .i_valid_data (vin), .o_r (r_s), .o_im (im_s), .o_valid_data (v_s)
  );

  cplx_mult #(
    .INPUT_WIDTH_I (4), .INPUT_WIDTH_II (4), .OUTPUT_WIDTH (4),
    .WRAP_SATURATE (cplx_mult_pkg::MODE_WRAP)
  ) dut_wrap (
    .i_clk (clk), .i_rst_p (rst), .i_a (a), .i_b (b), .i_c (c), .i_d (d),
    .i_valid_data (vin), .o_r (r_w), .o_im (im_w), .o_valid_data (v_w)
  );

  typedef struct {
    int a, b, c, d;
    int r_sat, im_sat, r_wrap, im_wrap;
  } vec_t;

  typedef struct {
    int due;
    int r_sat, im_sat, r_wrap, im_wrap;
  } exp_t;

  vec_t tbl[7];
  exp_t q[$];
  int   cyc;
  int   last_rs, last_is, last_rw, last_iw;
  int   n_cmp, n_fail;

  // Reference reduction from the arithmetic definition.
  function automatic int reduce(input int v, input bit sat);
    int lo, hi, m;
    lo = -(1 << (OW - 1));
    hi = (1 << (OW - 1)) - 1;
    if (sat) begin
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
    end
    m = v & ((1 << OW) - 1);
    if (m > hi) m = m - (1 << OW);
    return m;
  endfunction

  function automatic int s4(input logic [3:0] x);
    return int'($signed(x));
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance to the next falling edge, check against the model.
  task automatic tick(input bit r, input bit v, input int ia, input int ib,
                      input int ic, input int id);
    exp_t e;
    int   rf, imf;
    rst = r;
    vin = v;
    if (v) begin
      a = 4'(ia); b = 4'(ib); c = 4'(ic); d = 4'(id);
    end else begin
      a = 'x; b = 'x; c = 'x; d = 'x;
    end
    if (r) begin
      q.delete();
      last_rs = 0; last_is = 0; last_rw = 0; last_iw = 0;
    end else if (v) begin
      rf        = ia * ic - ib * id;
      imf       = ia * id + ib * ic;
      e.due     = cyc + 2;
      e.r_sat   = reduce(rf, 1'b1);
      e.im_sat  = reduce(imf, 1'b1);
      e.r_wrap  = reduce(rf, 1'b0);
      e.im_wrap = reduce(imf, 1'b0);
      q.push_back(e);
    end
    @(negedge clk);
    cyc++;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      last_rs = e.r_sat; last_is = e.im_sat; last_rw = e.r_wrap; last_iw = e.im_wrap;
      chk("valid_sat", int'(v_s), 1);
      chk("valid_wrap", int'(v_w), 1);
    end else begin
      chk("valid_sat", int'(v_s), 0);
      chk("valid_wrap", int'(v_w), 0);
    end
    chk("r_sat", s4(r_s), last_rs);
    chk("im_sat", s4(im_s), last_is);
    chk("r_wrap", s4(r_w), last_rw);
    chk("im_wrap", s4(im_w), last_iw);
  endtask

  function automatic int rnd4();
    return int'($urandom_range(0, 15)) - 8;
  endfunction

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0;
    last_rs = 0; last_is = 0; last_rw = 0; last_iw = 0;
    rst = 1'b1; vin = 1'b0; a = '0; b = '0; c = '0; d = '0;

    //           a   b   c   d  rSat imSat rWrap imWrap
    tbl[0] = '{  1,  2,  3, -1,   5,   5,   5,    5};
    tbl[1] = '{  3,  0,  3,  0,   7,   0,  -7,    0};
    tbl[2] = '{ -8, -8, -8, -8,   0,   7,   0,    0};
    tbl[3] = '{ -8,  0,  2,  0,  -8,   0,   0,    0};
    tbl[4] = '{  0,  3,  0,  3,  -8,   0,   7,    0};
    tbl[5] = '{  2, -3,  1,  2,   7,   1,  -8,    1};
    tbl[6] = '{ -8,  7,  7, -8,   0,   7,   0,    1};

    // Reset held two cycles with valid high, then two quiet cycles.
    tick(1'b1, 1'b1, 7, 7, 7, 7);
    tick(1'b1, 1'b1, -8, -8, -8, -8);
    tick(1'b0, 1'b0, 0, 0, 0, 0);
    tick(1'b0, 1'b0, 0, 0, 0, 0);

    // Directed table: result two cycles later, then held while idle.
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, 1'b1, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d);
      tick(1'b0, 1'b0, 0, 0, 0, 0);
      chk("tbl_r_sat", s4(r_s), tbl[i].r_sat);
      chk("tbl_im_sat", s4(im_s), tbl[i].im_sat);
      chk("tbl_r_wrap", s4(r_w), tbl[i].r_wrap);
      chk("tbl_im_wrap", s4(im_w), tbl[i].im_wrap);
      chk("tbl_pulse", int'(v_s), 1);
      tick(1'b0, 1'b0, 0, 0, 0, 0);
      chk("tbl_hold_r", s4(r_s), tbl[i].r_sat);
      chk("tbl_hold_im", s4(im_w), tbl[i].im_wrap);
      chk("tbl_pulse_end", int'(v_s), 0);
    end

    // Back-to-back random stream.
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b1, rnd4(), rnd4(), rnd4(), rnd4());
    end
    tick(1'b0, 1'b0, 0, 0, 0, 0);
    tick(1'b0, 1'b0, 0, 0, 0, 0);

    // Random stream with valid gaps.
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, bit'($urandom_range(0, 1)), rnd4(), rnd4(), rnd4(), rnd4());
    end
    tick(1'b0, 1'b0, 0, 0, 0, 0);
    tick(1'b0, 1'b0, 0, 0, 0, 0);

    // Reset one cycle after a valid sample: the sample must vanish.
    tick(1'b0, 1'b1, 3, -2, 5, 1);
    tick(1'b1, 1'b0, 0, 0, 0, 0);
    chk("rst_mid_valid", int'(v_s), 0);
    chk("rst_mid_r", s4(r_s), 0);
    chk("rst_mid_im", s4(im_w), 0);
    tick(1'b0, 1'b0, 0, 0, 0, 0);
    chk("rst_mid_no_late_pulse", int'(v_w), 0);
    tick(1'b0, 1'b1, 1, 2, 3, -1);
    tick(1'b0, 1'b0, 0, 0, 0, 0);
    chk("resume_r", s4(r_s), 5);
    chk("resume_im", s4(im_s), 5);
    chk("resume_valid", int'(v_s), 1);
    tick(1'b0, 1'b0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
